// File: rtl/mux_pipe_n_pkg.sv
// ---------------------------------------------------------------------------
// mux_pipe_pkg
// Shared helpers for the pipelined N:1 multiplexer tree.
//   clog2_min1(n)     : tree depth, never below 1 (so N=2 still gets a stage)
//   level_width(n, s) : number of partial results held after tree level s
//                       (level 0 is the raw channel count)
// Optional feature macro used by the users of this package: MUX_PIPE_N_ERR_EN
// ---------------------------------------------------------------------------
package mux_pipe_pkg;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Each 2:1 level halves the element count, an odd leftover passes through.
   function automatic int level_width(input int n, input int s);
      int w;
      w = n;
      for (int i = 0; i < s; i++) w = (w + 1) / 2;
      return w;
   endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// ---------------------------------------------------------------------------
// mux_pipe_n_if
// Handshake bundle for mux_pipe_n.
//   in_data  [N*WIDTH] : channel k at [k*WIDTH +: WIDTH]
//   in_sel   [LEVELS]  : channel index
//   in_valid / in_ready: upstream handshake
//   out_data [WIDTH]   : selected channel
//   out_valid/out_ready: downstream handshake
//   sel_err            : beat had in_sel >= N (only with MUX_PIPE_N_ERR_EN)
// Modports: slave = the mux, master = the agent driving/consuming it.
// ---------------------------------------------------------------------------
interface mux_pipe_n_if #(
   parameter int N      = 8,
   parameter int WIDTH  = 32,
   parameter int LEVELS = mux_pipe_pkg::clog2_min1(N)
);
   logic [N*WIDTH-1:0] in_data;
   logic [LEVELS-1:0]  in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
`ifdef MUX_PIPE_N_ERR_EN
   logic               sel_err;
`endif

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_valid
`ifdef MUX_PIPE_N_ERR_EN
      , output sel_err
`endif
   );

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid
`ifdef MUX_PIPE_N_ERR_EN
      , input sel_err
`endif
   );

endinterface

// File: rtl/mux_pipe_n_level.sv
// ---------------------------------------------------------------------------
// mux_pipe_level
// One 2:1 level of the select tree plus its pipeline register.
//   clk, reset_n : clock, async active-low reset
//   en           : global advance (low = hold everything)
//   vld_in       : valid of the beat arriving from the previous level
//   d_in         : IN_ELEMS partial results
//   sel_in       : remaining select bits; bit 0 is consumed here
//   vld_q, d_q   : registered valid and ceil(IN_ELEMS/2) results
//   sel_q        : registered select bits still needed downstream
//   err_in/err_q : out-of-range flag carried with the beat (MUX_PIPE_N_ERR_EN)
// ---------------------------------------------------------------------------
module mux_pipe_level
   import mux_pipe_pkg::*;
#(
   parameter int  IN_ELEMS  = 2,
   parameter int  WIDTH     = 32,
   parameter int  SEL_W     = 1,
   localparam int OUT_ELEMS = level_width(IN_ELEMS, 1),
   localparam int SQ_W      = (SEL_W > 1) ? SEL_W - 1 : 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            en,
   input  logic                            vld_in,
   input  logic [IN_ELEMS-1:0][WIDTH-1:0]  d_in,
   input  logic [SEL_W-1:0]                sel_in,
`ifdef MUX_PIPE_N_ERR_EN
   input  logic                            err_in,
   output logic                            err_q,
`endif
   output logic                            vld_q,
   output logic [OUT_ELEMS-1:0][WIDTH-1:0] d_q,
   output logic [SQ_W-1:0]                 sel_q
);

   logic [OUT_ELEMS-1:0][WIDTH-1:0] d_nxt;

   // Pair (2i, 2i+1); sel bit picks element 1. A trailing odd element has no
   // partner and is forwarded unchanged.
   for (genvar i = 0; i < OUT_ELEMS; i++) begin : g_pair
      if (2*i + 1 < IN_ELEMS) begin : g_mux
         assign d_nxt[i] = sel_in[0] ? d_in[2*i+1] : d_in[2*i];
      end else begin : g_pass
         assign d_nxt[i] = d_in[2*i];
      end
   end

   // Bubbles load zeros so no stale data lingers in an empty stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= 1'b0;
         d_q   <= '0;
      end else if (en) begin
         vld_q <= vld_in;
         d_q   <= vld_in ? d_nxt : '0;
      end
   end

   if (SEL_W > 1) begin : g_sel
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)  sel_q <= '0;
         else if (en)   sel_q <= vld_in ? sel_in[SEL_W-1:1] : '0;
      end
   end else begin : g_sel_last
      // Last level: every select bit has been consumed.
      assign sel_q = '0;
   end

`ifdef MUX_PIPE_N_ERR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  err_q <= 1'b0;
      else if (en)   err_q <= vld_in & err_in;
   end
`endif

endmodule

// File: rtl/mux_pipe_n.sv
// ---------------------------------------------------------------------------
// mux_pipe_n
// Pipelined N:1 multiplexer: binary tree of 2:1 levels with a register after
// each level, LEVELS cycles latency, one beat per cycle throughput.
//   clk     : rising-edge clock
//   reset_n : async active-low reset, flushes every in-flight beat
//   bus     : mux_pipe_n_if.slave (in_data/in_sel/in_valid/in_ready,
//             out_data/out_valid/out_ready, sel_err when enabled)
// Flow control is a single global stall: the whole pipe holds while the
// output beat is not taken, so in_ready = !(out_valid && !out_ready).
// Select values >= N produce an all-zero beat that is still transferred.
// Optional macro MUX_PIPE_N_ERR_EN: adds bus.sel_err flagging those beats.
// ---------------------------------------------------------------------------
module mux_pipe_n
   import mux_pipe_pkg::*;
#(
   parameter int N      = 8,
   parameter int WIDTH  = 32,
   parameter int LEVELS = clog2_min1(N)
) (
   input  logic       clk,
   input  logic       reset_n,
   mux_pipe_n_if.slave bus
);

   localparam logic [LEVELS:0] N_VAL = (LEVELS+1)'(N);

   logic                    stall;
   logic                    en;
   logic                    sel_oor;
   logic [LEVELS:0]         vld_pipe;
   logic [N-1:0][WIDTH-1:0] d_masked;

   assign stall        = vld_pipe[LEVELS] && !bus.out_ready;
   assign en           = !stall;
   assign bus.in_ready = en;

   // Odd pass-through paths could otherwise route a real channel to the
   // output for an out-of-range select, so such beats enter as all zeros.
   assign sel_oor  = {1'b0, bus.in_sel} >= N_VAL;
   assign d_masked = sel_oor ? '0 : bus.in_data;

   assign vld_pipe[0] = bus.in_valid;

`ifdef MUX_PIPE_N_ERR_EN
   logic [LEVELS:0] err_pipe;
   assign err_pipe[0] = sel_oor;
`endif

   for (genvar s = 1; s <= LEVELS; s++) begin : g_lvl
      localparam int IE  = level_width(N, s - 1);
      localparam int OE  = level_width(N, s);
      localparam int SW  = LEVELS - s + 1;
      localparam int SQW = (SW > 1) ? SW - 1 : 1;

      logic [IE-1:0][WIDTH-1:0] d_in;
      logic [SW-1:0]            sel_in;
      logic [OE-1:0][WIDTH-1:0] d_q;
      logic [SQW-1:0]           sel_q;

      if (s == 1) begin : g_first
         assign d_in   = d_masked;
         assign sel_in = bus.in_sel;
      end else begin : g_chain
         assign d_in   = g_lvl[s-1].d_q;
         assign sel_in = g_lvl[s-1].sel_q;
      end

      mux_pipe_level #(
         .IN_ELEMS (IE),
         .WIDTH    (WIDTH),
         .SEL_W    (SW)
      ) u_level (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (en),
         .vld_in  (vld_pipe[s-1]),
         .d_in    (d_in),
         .sel_in  (sel_in),
`ifdef MUX_PIPE_N_ERR_EN
         .err_in  (err_pipe[s-1]),
         .err_q   (err_pipe[s]),
`endif
         .vld_q   (vld_pipe[s]),
         .d_q     (d_q),
         .sel_q   (sel_q)
      );

      if (s == LEVELS) begin : g_out
         logic unused_sel;
         assign unused_sel   = ^sel_q;
         assign bus.out_data = d_q[0];
      end
   end

   assign bus.out_valid = vld_pipe[LEVELS];

`ifdef MUX_PIPE_N_ERR_EN
   assign bus.sel_err = err_pipe[LEVELS];
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// ---------------------------------------------------------------------------
// tb_mux_pipe_n
// Directed bench for mux_pipe_n in three configurations:
//   u_a: N=8 WIDTH=32, u_b: N=5 WIDTH=32, u_c: N=2 WIDTH=1.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Honours MUX_PIPE_N_ERR_EN for the sel_err checks.
// ---------------------------------------------------------------------------
module tb_mux_pipe_n;
   import mux_pipe_pkg::*;

   typedef struct {
      logic [2:0]  sel;
      logic [1:0]  din;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   vec_t tbl_b [8];
   vec_t tbl_c [8];

   mux_pipe_n_if #(.N(8), .WIDTH(32)) bus_a();
   mux_pipe_n_if #(.N(5), .WIDTH(32)) bus_b();
   mux_pipe_n_if #(.N(2), .WIDTH(1))  bus_c();

   mux_pipe_n #(.N(8), .WIDTH(32)) u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
   mux_pipe_n #(.N(5), .WIDTH(32)) u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
   mux_pipe_n #(.N(2), .WIDTH(1))  u_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int iptr;
      int optr;

      // N=5 table: selects 5..7 are out of range and must yield zero.
      tbl_b[0] = '{sel: 3'd6, din: 2'd0, exp_data: 32'h0000_0000, exp_err: 1'b1};
      tbl_b[1] = '{sel: 3'd4, din: 2'd0, exp_data: 32'hA000_0004, exp_err: 1'b0};
      tbl_b[2] = '{sel: 3'd3, din: 2'd0, exp_data: 32'hA000_0003, exp_err: 1'b0};
      tbl_b[3] = '{sel: 3'd5, din: 2'd0, exp_data: 32'h0000_0000, exp_err: 1'b1};
      tbl_b[4] = '{sel: 3'd7, din: 2'd0, exp_data: 32'h0000_0000, exp_err: 1'b1};
      tbl_b[5] = '{sel: 3'd0, din: 2'd0, exp_data: 32'hA000_0000, exp_err: 1'b0};
      tbl_b[6] = '{sel: 3'd1, din: 2'd0, exp_data: 32'hA000_0001, exp_err: 1'b0};
      tbl_b[7] = '{sel: 3'd2, din: 2'd0, exp_data: 32'hA000_0002, exp_err: 1'b0};

      // N=2 WIDTH=1 truth table: out = din[sel].
      tbl_c[0] = '{sel: 3'd0, din: 2'b00, exp_data: 32'd0, exp_err: 1'b0};
      tbl_c[1] = '{sel: 3'd0, din: 2'b01, exp_data: 32'd1, exp_err: 1'b0};
      tbl_c[2] = '{sel: 3'd0, din: 2'b10, exp_data: 32'd0, exp_err: 1'b0};
      tbl_c[3] = '{sel: 3'd0, din: 2'b11, exp_data: 32'd1, exp_err: 1'b0};
      tbl_c[4] = '{sel: 3'd1, din: 2'b00, exp_data: 32'd0, exp_err: 1'b0};
      tbl_c[5] = '{sel: 3'd1, din: 2'b01, exp_data: 32'd0, exp_err: 1'b0};
      tbl_c[6] = '{sel: 3'd1, din: 2'b10, exp_data: 32'd1, exp_err: 1'b0};
      tbl_c[7] = '{sel: 3'd1, din: 2'b11, exp_data: 32'd1, exp_err: 1'b0};

      bus_a.in_valid = 1'b0; bus_a.in_sel = '0; bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b0; bus_b.in_sel = '0; bus_b.out_ready = 1'b1;
      bus_c.in_valid = 1'b0; bus_c.in_sel = '0; bus_c.out_ready = 1'b1;
      bus_c.in_data  = '0;
      for (int k = 0; k < 8; k++) bus_a.in_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      for (int k = 0; k < 5; k++) bus_b.in_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);

      // ---- reset state ----
      #1;
      chk("rst_a_valid", 32'(bus_a.out_valid), 32'd0);
      chk("rst_a_data",  bus_a.out_data,       32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_a_valid", 32'(bus_a.out_valid), 32'd0);
      chk("post_rst_a_ready", 32'(bus_a.in_ready),  32'd1);
      chk("post_rst_b_valid", 32'(bus_b.out_valid), 32'd0);
      chk("post_rst_c_valid", 32'(bus_c.out_valid), 32'd0);
`ifdef MUX_PIPE_N_ERR_EN
      chk("post_rst_b_err",   32'(bus_b.sel_err),   32'd0);
`endif
      @(negedge clk);

      // ---- single beat sel=5, latency 3 ----
      for (int cyc = 0; cyc < 6; cyc++) begin
         bus_a.in_valid = (cyc == 0);
         bus_a.in_sel   = 3'd5;
         #1;
         chk("t1_valid", 32'(bus_a.out_valid), 32'(cyc == 3));
         if (cyc == 3) chk("t1_data", bus_a.out_data, 32'hA000_0005);
         chk("t1_in_ready", 32'(bus_a.in_ready), 32'd1);
         @(negedge clk);
      end

      // ---- back-to-back sel=0..7, no gaps ----
      for (int cyc = 0; cyc < 13; cyc++) begin
         bus_a.in_valid = (cyc < 8);
         bus_a.in_sel   = 3'(cyc);
         #1;
         chk("t2_valid", 32'(bus_a.out_valid), 32'(cyc >= 3 && cyc <= 10));
         if (cyc >= 3 && cyc <= 10)
            chk("t2_data", bus_a.out_data, 32'hA000_0000 + 32'(cyc - 3));
         chk("t2_in_ready", 32'(bus_a.in_ready), 32'd1);
         @(negedge clk);
      end

      // ---- backpressure: out_ready low for 4 cycles at first output ----
      iptr = 0;
      optr = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         bus_a.out_ready = !(cyc >= 3 && cyc <= 6);
         bus_a.in_valid  = (iptr < 4);
         bus_a.in_sel    = 3'(iptr + 1);
         #1;
         if (cyc >= 3 && cyc <= 6) begin
            chk("t3_hold_valid", 32'(bus_a.out_valid), 32'd1);
            chk("t3_hold_data",  bus_a.out_data,       32'hA000_0001);
            chk("t3_hold_ready", 32'(bus_a.in_ready),  32'd0);
         end
         if (bus_a.out_valid) begin
            if (optr < 4) chk("t3_order", bus_a.out_data, 32'hA000_0000 + 32'(optr + 1));
            else          chk("t3_extra", 32'(bus_a.out_valid), 32'd0);
            if (bus_a.out_ready) optr++;
         end
         if (bus_a.in_valid && bus_a.in_ready) iptr++;
         @(negedge clk);
      end
      bus_a.out_ready = 1'b1;
      chk("t3_out_count", 32'(optr), 32'd4);
      chk("t3_in_count",  32'(iptr), 32'd4);

      // ---- N=5 table, including out-of-range selects ----
      for (int cyc = 0; cyc < 12; cyc++) begin
         bus_b.in_valid = (cyc < 8);
         if (cyc < 8) bus_b.in_sel = tbl_b[cyc].sel;
         #1;
         chk("t4_valid", 32'(bus_b.out_valid), 32'(cyc >= 3 && cyc < 11));
         if (cyc >= 3 && cyc < 11) begin
            chk("t4_data", bus_b.out_data, tbl_b[cyc-3].exp_data);
`ifdef MUX_PIPE_N_ERR_EN
            chk("t4_sel_err", 32'(bus_b.sel_err), 32'(tbl_b[cyc-3].exp_err));
`endif
         end
         @(negedge clk);
      end

      // ---- reset mid-flight with three beats in the pipe ----
      for (int cyc = 0; cyc < 3; cyc++) begin
         bus_a.in_valid = 1'b1;
         bus_a.in_sel   = 3'(cyc + 1);
         @(negedge clk);
      end
      bus_a.in_valid = 1'b0;
      #1;
      chk("t5_pre_valid", 32'(bus_a.out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(bus_a.out_valid), 32'd0);
      chk("t5_rst_data",  bus_a.out_data,       32'd0);
      chk("t5_rst_ready", 32'(bus_a.in_ready),  32'd1);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         bus_a.in_valid = (cyc == 2);
         bus_a.in_sel   = 3'd2;
         #1;
         chk("t5_valid", 32'(bus_a.out_valid), 32'(cyc == 5));
         if (cyc == 5) chk("t5_data", bus_a.out_data, 32'hA000_0002);
         @(negedge clk);
      end

      // ---- N=2 WIDTH=1 exhaustive, latency 1 ----
      for (int cyc = 0; cyc < 10; cyc++) begin
         bus_c.in_valid = (cyc < 8);
         if (cyc < 8) begin
            bus_c.in_sel  = tbl_c[cyc].sel[0];
            bus_c.in_data = tbl_c[cyc].din;
         end
         #1;
         chk("t6_valid", 32'(bus_c.out_valid), 32'(cyc >= 1 && cyc <= 8));
         if (cyc >= 1 && cyc <= 8)
            chk("t6_data", 32'(bus_c.out_data), tbl_c[cyc-1].exp_data);
         chk("t6_in_ready", 32'(bus_c.in_ready), 32'd1);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_pipe_n.md
Name: mux_pipe_n

Overview:
- Parametrised, pipelined N-to-1 multiplexer. Successor to the single-bit 2:1 gate-level mux.
- Selects one of N WIDTH-bit channels through a binary tree of 2:1 levels, with a pipeline register after every tree level.
- Valid/ready handshake on both sides. Used for wide datapath selection (forwarding and writeback operand selection) where a flat 32:1 mux misses timing.

Parameters:
- N, default 8: number of input channels, N >= 2; N need not be a power of two.
- WIDTH, default 32: bits per channel.
- LEVELS, default $clog2(N): tree depth; derived, must not be overridden.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- in_data, input, N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel, input, LEVELS: channel index.
- in_valid, input, 1: input beat present.
- in_ready, output, 1: block accepts a beat this cycle.
- out_data, output, WIDTH: selected channel.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts the beat.

Behaviour:
- Reset: asserting reset_n low immediately clears all stage valids, data registers and sel remnants to 0.
  - out_valid=0 and out_data=0 during and after reset; in_ready=1 after reset.
  - Reset mid-flight discards every in-flight beat; no beat emerges after release.
- Stage structure:
  - Stage s (s=1..LEVELS) holds N/2^s partial results (rounded up), the remaining sel bits [LEVELS-1:s], and a valid bit.
  - Level s uses sel bit s-1 (LSB first) to pick pair element 1 over element 0.
  - An odd unpaired element passes straight through.
- Latency: exactly LEVELS cycles from accepted beat (in_valid && in_ready) to out_valid, with no backpressure. Throughput is one beat per cycle.
- Flow control: one global stall, stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stall is high, all stage registers hold.
  - When stall is low, every stage advances. A stage with no incoming valid loads valid=0; its data becomes don't-care but is driven to 0.
- Simultaneous events: out_ready and in_valid high together while full → output beat retires and new beat enters in the same cycle; no bubble.
- Out-of-range select (in_sel >= N, only possible when N is not a power of two): out_data=0 for that beat; the beat is still transferred.
- Bubbles: in_valid=0 beats propagate as valid=0; out_valid never asserts for them.
- Ordering: strictly in order; no beat is duplicated or dropped.

Optional Feature:
- Macro: MUX_PIPE_N_ERR_EN.
- Defined:
  - Adds output sel_err (1 bit), aligned with out_data.
  - sel_err=1 exactly when that beat's in_sel >= N; it is carried as one extra bit per stage.
  - Reset value 0; qualified by out_valid.
- Not defined: port absent, no extra flops; out-of-range beats still output 0.

Decomposition:
- Package mux_pipe_pkg holds:
  - function clog2_min1(n), returning at least 1 so that N=2 gives LEVELS=1;
  - localparam helper function level_width(n, s), giving the element count at level s.
- Sub-module mux_pipe_level: one combinational 2:1 level plus its register, valid bit and sel-shift.
  - Parameters: IN_ELEMS and WIDTH.
  - The top instantiates it LEVELS times in a generate loop.
- The existing mux2_1 cell is not reused; the level is behavioural RTL.

Test Plan:
- N=8, WIDTH=32, channel k = 32'hA000_0000+k, sel=5, in_valid pulse, out_ready=1 → out_valid at cycle+3, out_data=32'hA000_0005; in_ready stays 1.
- Back-to-back sel=0..7 over 8 cycles with out_ready=1 → 8 consecutive outputs A0000000..A0000007 starting cycle 3, no gaps.
- Stream sel=1,2,3,4 with out_ready low for 4 cycles when first output appears:
  - out_data holds A0000001 and in_ready=0 throughout;
  - on release, sequence 1,2,3,4 continues, nothing lost or duplicated.
- N=5 (LEVELS=3), sel=6 → out_data=0 after 3 cycles. With MUX_PIPE_N_ERR_EN, sel_err=1; with sel=4, data = channel 4 and sel_err=0.
- Three beats in flight, reset_n pulsed low mid-cycle → out_valid drops immediately. After release, no stale beats appear and a new sel=2 beat emerges after 3 cycles.
- N=2, WIDTH=1, exhaustive {sel,in} over 8 values → matches 2:1 truth table with 1-cycle latency.
